// File: rtl/texter_pkg.sv
// texter_pkg: shared types and constants for the Morse keyer
// Contents: keyer state enumeration, per-state unit multipliers,
//           counter/pattern/length widths and a unit-load helper.
// Build option: MORSE_DIGITS_EN widens the pattern to 5 elements for digits.
package texter_pkg;

    typedef enum logic [2:0] {
        IDLE,
        MARK,
        EGAP,
        CGAP,
        WGAP
    } state_t;

    localparam int CNT_W = 24;
    localparam int MUL_W = 3;
    localparam int LEN_W = 3;

`ifdef MORSE_DIGITS_EN
    localparam int PAT_W = 5;
`else
    localparam int PAT_W = 4;
`endif

    localparam logic [MUL_W-1:0] MUL_DIT  = 3'd1;
    localparam logic [MUL_W-1:0] MUL_DASH = 3'd3;
    localparam logic [MUL_W-1:0] MUL_EGAP = 3'd1;
    localparam logic [MUL_W-1:0] MUL_CGAP = 3'd3;
    localparam logic [MUL_W-1:0] MUL_WGAP = 3'd4;

    // Unit counter load value for an element: remaining units after the first.
    function automatic logic [MUL_W-1:0] elem_units(input logic dash);
        return (dash ? MUL_DASH : MUL_DIT) - 3'd1;
    endfunction

endpackage

// File: rtl/morse_rom.sv
// morse_rom: combinational ASCII-to-Morse pattern lookup
// Ports: char_in  - ASCII code (letters are case-folded)
//        pattern  - elements left-aligned, MSB sent first, 1 = dash
//        length   - number of elements (0 when unsupported)
//        valid    - character has a Morse pattern
// Build option: MORSE_DIGITS_EN adds '0'-'9'.
module morse_rom
    import texter_pkg::*;
(
    input  logic [7:0]       char_in,
    output logic [PAT_W-1:0] pattern,
    output logic [LEN_W-1:0] length,
    output logic             valid
);

    logic [7:0] w_up;
    logic [4:0] w_code;

    assign w_up = (char_in >= 8'h61 && char_in <= 8'h7a) ? char_in - 8'h20 : char_in;

    // Codes are right-aligned here and left-aligned on the way out.
    always_comb begin
        {length, w_code} = '0;
        case (w_up)
            "A": {length, w_code} = {3'd2, 5'b00001};
            "B": {length, w_code} = {3'd4, 5'b01000};
            "C": {length, w_code} = {3'd4, 5'b01010};
            "D": {length, w_code} = {3'd3, 5'b00100};
            "E": {length, w_code} = {3'd1, 5'b00000};
            "F": {length, w_code} = {3'd4, 5'b00010};
            "G": {length, w_code} = {3'd3, 5'b00110};
            "H": {length, w_code} = {3'd4, 5'b00000};
            "I": {length, w_code} = {3'd2, 5'b00000};
            "J": {length, w_code} = {3'd4, 5'b00111};
            "K": {length, w_code} = {3'd3, 5'b00101};
            "L": {length, w_code} = {3'd4, 5'b00100};
            "M": {length, w_code} = {3'd2, 5'b00011};
            "N": {length, w_code} = {3'd2, 5'b00010};
            "O": {length, w_code} = {3'd3, 5'b00111};
            "P": {length, w_code} = {3'd4, 5'b00110};
            "Q": {length, w_code} = {3'd4, 5'b01101};
            "R": {length, w_code} = {3'd3, 5'b00010};
            "S": {length, w_code} = {3'd3, 5'b00000};
            "T": {length, w_code} = {3'd1, 5'b00001};
            "U": {length, w_code} = {3'd3, 5'b00001};
            "V": {length, w_code} = {3'd4, 5'b00001};
            "W": {length, w_code} = {3'd3, 5'b00011};
            "X": {length, w_code} = {3'd4, 5'b01001};
            "Y": {length, w_code} = {3'd4, 5'b01011};
            "Z": {length, w_code} = {3'd4, 5'b01100};
`ifdef MORSE_DIGITS_EN
            "0": {length, w_code} = {3'd5, 5'b11111};
            "1": {length, w_code} = {3'd5, 5'b01111};
            "2": {length, w_code} = {3'd5, 5'b00111};
            "3": {length, w_code} = {3'd5, 5'b00011};
            "4": {length, w_code} = {3'd5, 5'b00001};
            "5": {length, w_code} = {3'd5, 5'b00000};
            "6": {length, w_code} = {3'd5, 5'b10000};
            "7": {length, w_code} = {3'd5, 5'b11000};
            "8": {length, w_code} = {3'd5, 5'b11100};
            "9": {length, w_code} = {3'd5, 5'b11110};
`endif
            default: ;
        endcase
    end

    assign valid   = length != '0;
    assign pattern = PAT_W'(w_code << (3'(PAT_W) - length));

endmodule

// File: rtl/morse_keyer.sv
// morse_keyer: sends ASCII letters (and spaces as word gaps) as Morse on key_out
// Ports: clk, reset (async, active-high)
//        char_valid/char_in - character offer, taken when ready is high
//        ready   - idle, accepting a character this cycle
//        key_out - Morse key, high = mark
//        busy    - inverse of ready
//        char_err- one-cycle pulse for an unsupported character
// Build option: MORSE_DIGITS_EN enables digits '0'-'9'.
module morse_keyer
    import texter_pkg::*;
#(
    parameter int DIT_CYCLES = 1620000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       char_valid,
    input  logic [7:0] char_in,
    output logic       ready,
    output logic       key_out,
    output logic       busy,
    output logic       char_err
);

    localparam logic [CNT_W-1:0] DIT_M1 = CNT_W'(DIT_CYCLES - 1);

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [MUL_W-1:0] r_units;
    logic [LEN_W-1:0] r_left;
    logic [PAT_W-1:0] r_pat;
    logic             r_key;
    logic             r_ready;
    logic             r_err;

    logic [PAT_W-1:0] w_pat;
    logic [LEN_W-1:0] w_len;
    logic             w_valid;
    logic             w_last;
    logic             w_space;

    morse_rom u_rom (
        .char_in (char_in),
        .pattern (w_pat),
        .length  (w_len),
        .valid   (w_valid)
    );

    assign w_last  = r_cnt == '0 && r_units == '0;
    assign w_space = char_in == 8'h20;

    // CGAP leaves one cycle early so the IDLE cycle (ready high) is the
    // final cycle of the character gap and a next letter follows seamlessly.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_units <= '0;
            r_left  <= '0;
            r_pat   <= '0;
            r_key   <= 1'b0;
            r_ready <= 1'b1;
            r_err   <= 1'b0;
        end else begin
            r_err <= 1'b0;
            if (r_state != IDLE) begin
                r_cnt <= (r_cnt == '0) ? DIT_M1 : r_cnt - CNT_W'(1);
                if (r_cnt == '0 && r_units != '0) r_units <= r_units - 3'd1;
            end
            case (r_state)
                IDLE: begin
                    if (!r_ready) r_ready <= 1'b1;
                    else if (char_valid) begin
                        r_ready <= 1'b0;
                        r_cnt   <= DIT_M1;
                        if (w_valid) begin
                            r_state <= MARK;
                            r_key   <= 1'b1;
                            r_units <= elem_units(w_pat[PAT_W-1]);
                            r_pat   <= w_pat << 1;
                            r_left  <= w_len - LEN_W'(1);
                        end else if (w_space) begin
                            r_state <= WGAP;
                            r_units <= MUL_WGAP - 3'd1;
                        end else r_err <= 1'b1;
                    end
                end
                MARK: begin
                    if (w_last) begin
                        r_key   <= 1'b0;
                        r_state <= (r_left != '0) ? EGAP : CGAP;
                        r_units <= ((r_left != '0) ? MUL_EGAP : MUL_CGAP) - 3'd1;
                    end
                end
                EGAP: begin
                    if (w_last) begin
                        r_state <= MARK;
                        r_key   <= 1'b1;
                        r_units <= elem_units(r_pat[PAT_W-1]);
                        r_pat   <= r_pat << 1;
                        r_left  <= r_left - LEN_W'(1);
                    end
                end
                CGAP: begin
                    if (r_units == '0 && r_cnt == CNT_W'(1)) begin
                        r_state <= IDLE;
                        r_ready <= 1'b1;
                    end
                end
                WGAP: begin
                    if (w_last) begin
                        r_state <= IDLE;
                        r_ready <= 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign ready    = r_ready;
    assign busy     = ~r_ready;
    assign key_out  = r_key;
    assign char_err = r_err;

endmodule

// File: tb/tb_morse_keyer.sv
// tb_morse_keyer: table-driven check of the Morse keyer at DIT_CYCLES=4
module tb_morse_keyer;

    localparam int DIT   = 4;
    localparam int K_LET = 0;
    localparam int K_SPC = 1;
    localparam int K_ERR = 2;

    logic       clk = 1'b0;
    logic       reset;
    logic       char_valid;
    logic [7:0] char_in;
    logic       ready;
    logic       key_out;
    logic       busy;
    logic       char_err;

    int n_pass = 0;
    int n_chk  = 0;

    typedef struct {
        byte unsigned ch;
        int           kind;
        string        elems;
    } vec_t;

    vec_t tv[$];

    morse_keyer #(.DIT_CYCLES(DIT)) dut (
        .clk        (clk),
        .reset      (reset),
        .char_valid (char_valid),
        .char_in    (char_in),
        .ready      (ready),
        .key_out    (key_out),
        .busy       (busy),
        .char_err   (char_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    // Sends one character at a negedge where ready is high, then samples every
    // negedge until ready returns, comparing against a waveform built from elems.
    task automatic run(input byte unsigned ch, input int kind, input string elems, input bit hold_junk);
        logic  ek [0:255];
        int    c, r_exp, r_act, errs, err_at, bad_wave, bad_busy;
        string nm;
        nm = $sformatf("'%c'", ch);
        for (int i = 0; i < 256; i++) ek[i] = 1'b0;
        c = 1;
        if (kind == K_LET) begin
            for (int i = 0; i < elems.len(); i++) begin
                for (int j = 0; j < ((elems[i] == "-") ? 3 * DIT : DIT); j++) begin
                    ek[c] = 1'b1;
                    c++;
                end
                c += (i == elems.len() - 1) ? 3 * DIT : DIT;
            end
            r_exp = c - 1;
        end else if (kind == K_SPC) r_exp = 4 * DIT + 1;
        else r_exp = 2;
        for (int k = 0; k < 200 && !ready; k++) @(negedge clk);
        check({nm, " ready before send"}, int'(ready), 1);
        char_in    = ch;
        char_valid = 1'b1;
        @(negedge clk);
        char_valid = hold_junk;
        char_in    = hold_junk ? 8'h23 : ch;
        r_act = -1; errs = 0; err_at = -1; bad_wave = 0; bad_busy = 0;
        for (c = 1; c <= 200; c++) begin
            if (hold_junk && c == 10) char_valid = 1'b0;
            if (key_out !== ek[c] && bad_wave == 0) bad_wave = c;
            if (busy !== ~ready && bad_busy == 0) bad_busy = c;
            if (char_err === 1'b1) begin
                errs++;
                if (err_at < 0) err_at = c;
            end
            if (ready === 1'b1) begin
                r_act = c;
                break;
            end
            @(negedge clk);
        end
        check({nm, " ready cycle"}, r_act, r_exp);
        check({nm, " key wave first bad cycle"}, bad_wave, 0);
        check({nm, " busy!=~ready first bad cycle"}, bad_busy, 0);
        check({nm, " char_err pulses"}, errs, (kind == K_ERR) ? 1 : 0);
        if (kind == K_ERR) check({nm, " char_err cycle"}, err_at, 1);
    endtask

    initial begin
        tv.push_back('{8'h45, K_LET, "."});
        tv.push_back('{8'h61, K_LET, ".-"});
        tv.push_back('{8'h41, K_LET, ".-"});
        tv.push_back('{8'h54, K_LET, "-"});
        tv.push_back('{8'h20, K_SPC, ""});
        tv.push_back('{8'h4f, K_LET, "---"});
        tv.push_back('{8'h51, K_LET, "--.-"});
        tv.push_back('{8'h7a, K_LET, "--.."});
        tv.push_back('{8'h53, K_LET, "..."});
        tv.push_back('{8'h68, K_LET, "...."});
        tv.push_back('{8'h23, K_ERR, ""});
        tv.push_back('{8'h40, K_ERR, ""});
        tv.push_back('{8'h5b, K_ERR, ""});
        tv.push_back('{8'h60, K_ERR, ""});
        tv.push_back('{8'h7b, K_ERR, ""});
        tv.push_back('{8'h59, K_LET, "-.--"});
`ifdef MORSE_DIGITS_EN
        tv.push_back('{8'h35, K_LET, "....."});
        tv.push_back('{8'h30, K_LET, "-----"});
        tv.push_back('{8'h37, K_LET, "--..."});
`else
        tv.push_back('{8'h35, K_ERR, ""});
        tv.push_back('{8'h30, K_ERR, ""});
`endif

        reset      = 1'b1;
        char_valid = 1'b0;
        char_in    = 8'h00;
        #1;
        check("reset ready", int'(ready), 1);
        check("reset key_out", int'(key_out), 0);
        check("reset busy", int'(busy), 0);
        check("reset char_err", int'(char_err), 0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("idle ready", int'(ready), 1);

        foreach (tv[i]) run(tv[i].ch, tv[i].kind, tv[i].elems, 1'b0);

        // char_valid held with junk while busy must be ignored
        run(8'h45, K_LET, ".", 1'b1);

        // reset in the middle of the first dash of 'O'
        char_in    = 8'h4f;
        char_valid = 1'b1;
        @(negedge clk);
        char_valid = 1'b0;
        repeat (5) @(negedge clk);
        check("O mid-dash key_out", int'(key_out), 1);
        #1 reset = 1'b1;
        #1;
        check("abort key_out", int'(key_out), 0);
        check("abort ready", int'(ready), 1);
        check("abort busy", int'(busy), 0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        run(8'h45, K_LET, ".", 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/morse_keyer.md
MORSE_KEYER -- requirements
Module: morse_keyer

Interface
REQ-001 SHALL have parameter DIT_CYCLES, default 1620000, clock cycles per Morse unit (60 ms at 27 MHz); legal range 2..2^24-1.
REQ-002 SHALL have port clk  input  1  single system clock, rising-edge active.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port char_valid  input  1  character offered on char_in.
REQ-005 SHALL have port char_in  input  8  ASCII character to send.
REQ-006 SHALL have port ready  output  1  keyer idle; accepts a character this cycle.
REQ-007 SHALL have port key_out  output  1  Morse key, high = tone/mark.
REQ-008 SHALL have port busy  output  1  high while a character or word gap is being sent.
REQ-009 SHALL have port char_err  output  1  one-cycle pulse on an unsupported character.

Function
REQ-010 SHALL accept a character on any rising edge where char_valid=1 and ready=1; ready SHALL be low from the next cycle until the transfer completes.
REQ-011 SHALL map 'A'-'Z' and 'a'-'z' (case-folded) to ITU Morse patterns of 1-4 elements.
REQ-012 SHALL treat 0x20 (space) as a word gap: key_out low for 4 units, then return to IDLE.
REQ-013 SHALL, for any other code, pulse char_err for one cycle, leave key_out low, and return to IDLE on the following cycle.
REQ-014 SHALL drive key_out high for 1 unit per dit and 3 units per dash, first mark starting the cycle after acceptance.
REQ-015 SHALL insert 1 unit of key_out low between elements of one character.
REQ-016 SHALL insert 3 units of key_out low after the last element; ready SHALL rise on the final cycle of that gap.
REQ-017 SHALL use a state machine with states IDLE, MARK, EGAP, CGAP, WGAP.
REQ-018 Transitions: IDLE->MARK (letter accepted), IDLE->WGAP (space), MARK->EGAP (more elements), MARK->CGAP (last element), EGAP->MARK, CGAP->IDLE, WGAP->IDLE.
REQ-019 SHALL time units with a 24-bit down counter and count the remaining elements with a 3-bit counter; a pattern shift register SHALL present the MSB element first.
REQ-020 SHALL keep key_out, ready and busy registered (glitch-free); busy SHALL equal the inverse of ready.
REQ-021 SHALL ignore char_valid while ready=0, without error or buffering.

Reset
REQ-022 SHALL, on reset=1, immediately enter IDLE with key_out=0, busy=0, char_err=0, ready=1 and all counters cleared.
REQ-023 SHALL abort any transmission in progress when reset is asserted mid-character; key_out SHALL fall asynchronously.

Configuration
REQ-024 With macro MORSE_DIGITS_EN defined, SHALL also accept '0'-'9' as their 5-element patterns; the element counter and pattern register SHALL widen to 5.
REQ-025 Without MORSE_DIGITS_EN, digits SHALL be treated as unsupported (char_err pulse).

Structure
REQ-026 SHALL place the state enumeration, the unit multipliers (1, 3, 1, 3, 4) and the pattern/length widths in shared package texter_pkg.
REQ-027 SHALL implement the character-to-pattern lookup as combinational sub-module morse_rom (outputs: pattern, length, valid).

Verification (DIT_CYCLES=4)
REQ-028 'E' accepted at cycle 0 -> key_out high cycles 1-4, low 5-16; ready high again at cycle 16; no char_err.
REQ-029 'a' accepted -> key_out high 4, low 4, high 12, low 12; identical to 'A'.
REQ-030 '#' accepted -> char_err high exactly one cycle, key_out never high, ready back high within 2 cycles.
REQ-031 'T' then ' ' back-to-back -> 12-cycle mark, 12 low, 16 low (28 cycles of silence total) before ready.
REQ-032 reset asserted mid-dash of 'O' -> key_out 0 in the same cycle, ready=1; a subsequent 'E' keys normally.
REQ-033 '5' accepted -> five 4-cycle marks when MORSE_DIGITS_EN is defined; a char_err pulse when it is undefined.
